// File: rtl/excpt_pkg.sv
// Shared encodings for the exception sequencer: FSM states,
// ExcptCtrl mux select codes and the handler vector byte addresses.
package excpt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SAVE = 3'd1,
    ST_WAIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [2:0] EXC_OPCODE = 3'b000;
  localparam logic [2:0] EXC_OVF    = 3'b001;
  localparam logic [2:0] EXC_DIV0   = 3'b010;

  localparam logic [7:0] VEC_OPCODE = 8'd253;
  localparam logic [7:0] VEC_OVF    = 8'd254;
  localparam logic [7:0] VEC_DIV0   = 8'd255;

endpackage

// File: rtl/excpt_prio_enc.sv
// Fixed-priority encoder, opcode > ovf > div0.
// req_i {div0,ovf,opcode} -> valid_o, code_o (ExcptCtrl), grant_o one-hot.
module excpt_prio_enc
  import excpt_pkg::*;
(
  input  logic [2:0] req_i,
  output logic       valid_o,
  output logic [2:0] code_o,
  output logic [2:0] grant_o
);

  always_comb begin
    valid_o = |req_i;
    code_o  = EXC_OPCODE;
    grant_o = 3'b000;
    priority case (1'b1)
      req_i[0]: begin
        code_o  = EXC_OPCODE;
        grant_o = 3'b001;
      end
      req_i[1]: begin
        code_o  = EXC_OVF;
        grant_o = 3'b010;
      end
      req_i[2]: begin
        code_o  = EXC_DIV0;
        grant_o = 3'b100;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/excpt_sequencer.sv
// Exception sequencer: arbitrates opcode/ovf/div0 requests and steps
// SAVE (EPC write) -> WAIT (vector read, MEM_LAT cycles) -> LOAD (PC
// write) -> DONE. Ports: clk, reset (async, active low), *_req, pc_in,
// mem_byte in; ExcptCtrl, mem_rd, epc_wr, epc_out, pc_wr, pc_out,
// busy, done out. Define EXCPT_PENDING_EN to keep losing/busy-time
// requests in a pending register instead of dropping them.
module excpt_sequencer
  import excpt_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned PC_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            opcode_req,
  input  logic            ovf_req,
  input  logic            div0_req,
  input  logic [PC_W-1:0] pc_in,
  input  logic [7:0]      mem_byte,
  output logic [2:0]      ExcptCtrl,
  output logic            mem_rd,
  output logic            epc_wr,
  output logic [PC_W-1:0] epc_out,
  output logic            pc_wr,
  output logic [PC_W-1:0] pc_out,
  output logic            busy,
  output logic            done
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic            mem_rd_q, epc_wr_q, pc_wr_q;
  logic            busy_q, done_q;

  logic [2:0] req_v;
  logic [2:0] arb_in;
  logic       win_v;
  logic [2:0] win_code;
  logic [2:0] win_grant;

  assign req_v = {div0_req, ovf_req, opcode_req};

`ifdef EXCPT_PENDING_EN
  logic [2:0] pend_q, pend_d;

  assign arb_in = pend_q | req_v;

  // Everything seen outside an acceptance is remembered; on
  // acceptance only the serviced bit is retired.
  always_comb begin
    pend_d = pend_q | req_v;
    if (state_q == ST_IDLE && win_v)
      pend_d = arb_in & ~win_grant;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= 3'b000;
    else        pend_q <= pend_d;
  end
`else
  assign arb_in = req_v;
`endif

  excpt_prio_enc u_prio (
    .req_i   (arb_in),
    .valid_o (win_v),
    .code_o  (win_code),
    .grant_o (win_grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    epc_d   = epc_q;
    unique case (state_q)
      ST_IDLE: begin
        ctrl_d = EXC_OPCODE;
        if (win_v) begin
          state_d = ST_SAVE;
          ctrl_d  = win_code;
          epc_d   = pc_in - PC_W'(4);
        end
      end
      ST_SAVE: begin
        state_d = ST_WAIT;
        cnt_d   = 3'd0;
      end
      ST_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = ST_LOAD;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        ctrl_d  = EXC_OPCODE;
      end
      default: begin
        state_d = ST_IDLE;
        ctrl_d  = EXC_OPCODE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Outputs are flopped from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      ctrl_q   <= EXC_OPCODE;
      epc_q    <= '0;
      mem_rd_q <= 1'b0;
      epc_wr_q <= 1'b0;
      pc_wr_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      epc_q    <= epc_d;
      mem_rd_q <= (state_d == ST_SAVE) ||
                  (state_d == ST_WAIT);
      epc_wr_q <= (state_d == ST_SAVE);
      pc_wr_q  <= (state_d == ST_LOAD);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign ExcptCtrl = ctrl_q;
  assign mem_rd    = mem_rd_q;
  assign epc_wr    = epc_wr_q;
  assign epc_out   = epc_q;
  assign pc_wr     = pc_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Memory returns the byte in the LOAD cycle itself, so it passes
  // straight through; gated so pc_out is zero outside LOAD.
  assign pc_out = pc_wr_q ? {{(PC_W-8){1'b0}}, mem_byte}
                          : '0;

endmodule

// File: tb/tb_excpt_sequencer.sv
// Bench for excpt_sequencer: two instances (MEM_LAT 1 and 3) share
// stimulus and are checked every cycle against a timeline model.
module tb_excpt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        opc, ovf, dv0;
  logic [31:0] pc_in;
  logic [7:0]  mem_byte;

  logic [2:0]  x_ctrl   [2];
  logic        x_mem_rd [2];
  logic        x_epc_wr [2];
  logic [31:0] x_epc    [2];
  logic        x_pc_wr  [2];
  logic [31:0] x_pc     [2];
  logic        x_busy   [2];
  logic        x_done   [2];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  excpt_sequencer #(.MEM_LAT(1), .PC_W(32)) u_l1 (
    .clk(clk), .reset(reset),
    .opcode_req(opc), .ovf_req(ovf), .div0_req(dv0),
    .pc_in(pc_in), .mem_byte(mem_byte),
    .ExcptCtrl(x_ctrl[0]), .mem_rd(x_mem_rd[0]),
    .epc_wr(x_epc_wr[0]), .epc_out(x_epc[0]),
    .pc_wr(x_pc_wr[0]), .pc_out(x_pc[0]),
    .busy(x_busy[0]), .done(x_done[0])
  );

  excpt_sequencer #(.MEM_LAT(3), .PC_W(32)) u_l3 (
    .clk(clk), .reset(reset),
    .opcode_req(opc), .ovf_req(ovf), .div0_req(dv0),
    .pc_in(pc_in), .mem_byte(mem_byte),
    .ExcptCtrl(x_ctrl[1]), .mem_rd(x_mem_rd[1]),
    .epc_wr(x_epc_wr[1]), .epc_out(x_epc[1]),
    .pc_wr(x_pc_wr[1]), .pc_out(x_pc[1]),
    .busy(x_busy[1]), .done(x_done[1])
  );

  // Model: k = cycles since acceptance (0 = idle). A sequence is
  // SAVE at k=1, WAIT k=2..1+L, LOAD k=2+L, DONE k=3+L.
  int          lat [2] = '{1, 3};
  int          k   [2];
  logic [2:0]  m_code [2];
  logic [31:0] m_epc  [2];
  logic [2:0]  m_pend [2];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; m_code[i] = 3'b000;
      m_epc[i] = 32'h0; m_pend[i] = 3'b000;
    end
  endtask

  task automatic model_step();
    logic [2:0] r, avail;
    int idx;
    r = {dv0, ovf, opc};
    for (int i = 0; i < 2; i++) begin
      if (k[i] == 0) begin
`ifdef EXCPT_PENDING_EN
        avail = r | m_pend[i];
`else
        avail = r;
`endif
        if (avail != 3'b000) begin
          idx = avail[0] ? 0 : (avail[1] ? 1 : 2);
          m_code[i] = 3'(idx);
          m_epc[i]  = pc_in - 32'd4;
`ifdef EXCPT_PENDING_EN
          m_pend[i] = avail & ~(3'b001 << idx);
`endif
          k[i] = 1;
        end
      end else begin
`ifdef EXCPT_PENDING_EN
        m_pend[i] = m_pend[i] | r;
`endif
        k[i] = (k[i] >= 3 + lat[i]) ? 0 : k[i] + 1;
      end
    end
  endtask

  task automatic check_all();
    string p;
    int L;
    logic pw;
    for (int i = 0; i < 2; i++) begin
      p  = (i == 0) ? "L1" : "L3";
      L  = lat[i];
      pw = (k[i] == 2 + L);
      chk({p, "_busy"},   32'(x_busy[i]),   32'(k[i] != 0));
      chk({p, "_epc_wr"}, 32'(x_epc_wr[i]), 32'(k[i] == 1));
      chk({p, "_mem_rd"}, 32'(x_mem_rd[i]),
          32'(k[i] >= 1 && k[i] <= 1 + L));
      chk({p, "_pc_wr"},  32'(x_pc_wr[i]),  32'(pw));
      chk({p, "_done"},   32'(x_done[i]),   32'(k[i] == 3 + L));
      chk({p, "_ctrl"},   32'(x_ctrl[i]),
          32'(k[i] != 0 ? m_code[i] : 3'b000));
      chk({p, "_epc"},    x_epc[i], m_epc[i]);
      chk({p, "_pc_out"}, x_pc[i],
          pw ? {24'h0, mem_byte} : 32'h0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    tick();
    reset = 1'b1;
  endtask

  int rd_cnt, dn_cnt;
  logic [31:0] seen_pc;

  initial begin
    reset = 1'b0;
    {opc, ovf, dv0} = 3'b000;
    pc_in = 32'h0; mem_byte = 8'h0;
    model_reset();
    #2;
    check_all();
    ticks(2);
    reset = 1'b1;
    ticks(2);

    // 1: ovf pulse, pc 0x100, vector byte 0x40
    pc_in = 32'h100; mem_byte = 8'h40; ovf = 1'b1;
    tick();
    ovf = 1'b0;
    chk("t1_epc", x_epc[0], 32'hFC);
    chk("t1_ctrl", 32'(x_ctrl[0]), 32'(3'b001));
    chk("t1_epc_wr", 32'(x_epc_wr[0]), 32'd1);
    ticks(2);
    chk("t1_pc_out", x_pc[0], 32'h40);
    tick();
    chk("t1_done", 32'(x_done[0]), 32'd1);
    ticks(6);

    // 2: opcode + div0 on the same edge
    opc = 1'b1; dv0 = 1'b1;
    tick();
    opc = 1'b0; dv0 = 1'b0;
    chk("t2_ctrl", 32'(x_ctrl[0]), 32'(3'b000));
    ticks(16);

    // 3: div0, vector byte 0xFF, watch the MEM_LAT=3 instance
    mem_byte = 8'hFF; dv0 = 1'b1;
    rd_cnt = 0; seen_pc = 32'h0;
    tick();
    dv0 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (x_mem_rd[1]) rd_cnt++;
      if (x_pc_wr[1]) seen_pc = x_pc[1];
      tick();
    end
    chk("t3_mem_rd_cycles", 32'(rd_cnt), 32'd4);
    chk("t3_pc_out", seen_pc, 32'h000000FF);

    // 4: reset during WAIT, then a normal request
    dv0 = 1'b1;
    tick();
    dv0 = 1'b0;
    ticks(2);
    chk("t4_in_wait", 32'(x_busy[1]), 32'd1);
    async_reset();
    dn_cnt = 0;
    for (int j = 0; j < 8; j++) begin
      if (x_done[0] || x_done[1] || x_pc_wr[0] || x_pc_wr[1])
        dn_cnt++;
      tick();
    end
    chk("t4_no_pc_wr_after_rst", 32'(dn_cnt), 32'd0);
    ovf = 1'b1; mem_byte = 8'h12;
    tick();
    ovf = 1'b0;
    ticks(8);

    // 5: pc_in = 0 wraps EPC
    pc_in = 32'h0; ovf = 1'b1;
    tick();
    ovf = 1'b0;
    chk("t5_epc", x_epc[0], 32'hFFFFFFFC);
    ticks(8);

    // 6: request held continuously
    opc = 1'b1;
    dn_cnt = 0;
    for (int j = 0; j < 25; j++) begin
      tick();
      if (x_done[0]) dn_cnt++;
    end
    opc = 1'b0;
    chk("t6_dones_L1", 32'(dn_cnt), 32'd5);
    ticks(10);

    // Random traffic with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      opc      = ($urandom_range(0, 9) == 0);
      ovf      = ($urandom_range(0, 9) == 0);
      dv0      = ($urandom_range(0, 9) == 0);
      pc_in    = $urandom;
      mem_byte = 8'($urandom);
      if ($urandom_range(0, 149) == 0) async_reset();
      else tick();
    end
    {opc, ovf, dv0} = 3'b000;
    ticks(12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
